// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, special instruction words
// and the opcodes decode uses to form redirect requests.
package fetch_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HALT   = 2'd3
    } fetch_state_e;

    // Bubble injected whenever the fetch stage has nothing real to offer.
    localparam logic [31:0] FETCH_NOP_WORD = 32'hF800_0000;
    // Program-terminate marker placed at the end of every ROM image.
    localparam logic [31:0] FETCH_END_WORD = 32'hFFFF_FFFF;

    // Control-transfer opcodes recognised downstream to raise redirect_i.
    localparam logic [4:0] OPC_J   = 5'd16;
    localparam logic [4:0] OPC_BEQ = 5'd4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating counter pair tracking delivered instructions and stall cycles.
// Counters stick at all-ones and hold while freeze is high.
module fetch_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_inc,
    input  logic             stall_inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_stall
);

    // Count events unless frozen or already saturated.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fetch <= '0;
            cnt_stall <= '0;
        end else if (!freeze) begin
            if (fetch_inc && (cnt_fetch != '1)) cnt_fetch <= cnt_fetch + CNT_W'(1);
            if (stall_inc && (cnt_stall != '1)) cnt_stall <= cnt_stall + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch controller in front of a synchronous ROM.
// Covers the one-cycle ROM latency, squashes the wrong-path word after a
// redirect, holds on stalls and freezes once the END word is fetched.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_WORD = FETCH_NOP_WORD,
    parameter logic [31:0]     END_WORD = FETCH_END_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic [31:0]     instr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] instr_pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o,
    output logic            halted_o,
    output logic [31:0]     cnt_fetch_o,
    output logic [31:0]     cnt_stall_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic            pc_load;
    logic            step_load;
    logic [PC_W-1:0] step_pc;
    logic            is_end;
    logic            fwd;

    assign is_end = (instr_i == END_WORD);

    // Pass the ROM word through only in RUN; everything else becomes a bubble.
    assign fwd     = (state_q == ST_RUN) && !is_end;
    assign instr_o = fwd ? instr_i : NOP_WORD;
    assign valid_o = fwd && !stall_i;

    // Common redirect/stall/advance step shared by BOOT, RUN and SQUASH.
    // Redirect beats stall; the increment wraps naturally at 2^PC_W.
    always_comb begin
        step_load = redirect_i || !stall_i;
        step_pc   = redirect_i ? redirect_pc_i : (pc_o + PC_W'(1));
    end

    // Next-state and next-PC selection.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_o;
        pc_load = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_load = step_load;
                pc_d    = step_pc;
            end
            ST_RUN: begin
                if (is_end) begin
                    state_d = ST_HALT;
                end else begin
                    pc_load = step_load;
                    pc_d    = step_pc;
                    if (redirect_i) state_d = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                pc_load = step_load;
                pc_d    = step_pc;
                state_d = redirect_i ? ST_SQUASH : ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC pair and halt flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_o       <= RESET_PC;
            instr_pc_o <= RESET_PC;
            halted_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_o <= (state_d == ST_HALT);
            if (pc_load) begin
                pc_o       <= pc_d;
                instr_pc_o <= pc_o;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt #(
        .CNT_W (32)
    ) u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_inc (valid_o),
        .stall_inc (stall_i && (state_q == ST_RUN)),
        .freeze    (state_q == ST_HALT),
        .cnt_fetch (cnt_fetch_o),
        .cnt_stall (cnt_stall_o)
    );
`else
    assign cnt_fetch_o = '0;
    assign cnt_stall_o = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a registered ROM model.
// Expected counter values depend on FETCH_PERF_CNT_EN.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] NOP = 32'hF800_0000;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] instr_i;
    logic [31:0] pc_o, instr_pc_o, instr_o, cnt_fetch_o, cnt_stall_o;
    logic        valid_o, halted_o;

    logic       sat_rst_n = 1'b0;
    logic       sat_fetch = 1'b0, sat_stall = 1'b0, sat_freeze = 1'b0;
    logic [2:0] sat_cnt_fetch, sat_cnt_stall;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_i       (instr_i),
        .pc_o          (pc_o),
        .instr_pc_o    (instr_pc_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o),
        .halted_o      (halted_o),
        .cnt_fetch_o   (cnt_fetch_o),
        .cnt_stall_o   (cnt_stall_o)
    );

    fetch_perf_cnt #(.CNT_W(3)) u_sat (
        .clk       (clk),
        .rst_n     (sat_rst_n),
        .fetch_inc (sat_fetch),
        .stall_inc (sat_stall),
        .freeze    (sat_freeze),
        .cnt_fetch (sat_cnt_fetch),
        .cnt_stall (sat_cnt_stall)
    );

    // ROM image: END at address 19, otherwise a word tagged with its address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'd19) return ENDW;
        return 32'h1000_0000 | {16'h0000, a[15:0]};
    endfunction

    // Synchronous ROM: data for the address presented one cycle earlier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) instr_i <= NOP;
        else        instr_i <= rom_word(pc_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        #2;
        n_checks++; if (pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'd0); end
        n_checks++; if (instr_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want %h", instr_pc_o, 32'd0); end
        n_checks++; if (instr_o !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_o, NOP); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted_o); end
        n_checks++; if (cnt_fetch_o !== 32'd0 || cnt_stall_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_fetch_o, cnt_stall_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (instr_pc_o !== 32'(i)) begin n_fail++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, instr_pc_o, 32'(i)); end
            n_checks++; if (pc_o !== 32'(i + 1)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_o, 32'(i + 1)); end
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, valid_o); end
            n_checks++; if (instr_o !== rom_word(32'(i))) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr_o, rom_word(32'(i))); end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_valid_now: got %b want 0", valid_o); end
        n_checks++; if (instr_o !== rom_word(32'd3)) begin n_fail++; $display("FAIL stall_instr_now: got %h want %h", instr_o, rom_word(32'd3)); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (pc_o !== 32'd4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", k, pc_o, 32'd4); end
            n_checks++; if (instr_pc_o !== 32'd3) begin n_fail++; $display("FAIL stall_instr_pc[%0d]: got %h want %h", k, instr_pc_o, 32'd3); end
            n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 0", k, valid_o); end
        end
        n_checks++; if (cnt_stall_o !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", cnt_stall_o, PERF ? 3 : 0); end
        stall_i = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b want 1", valid_o); end
        tick();
        n_checks++; if (pc_o !== 32'd5 || instr_pc_o !== 32'd4) begin n_fail++; $display("FAIL stall_resume: got pc %h/%h want 5/4", pc_o, instr_pc_o); end
        n_checks++; if (cnt_fetch_o !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL stall_fetch_cnt: got %0d want %0d", cnt_fetch_o, PERF ? 4 : 0); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (pc_o !== 32'd11) begin n_fail++; $display("FAIL redir_pre_pc: got %h want %h", pc_o, 32'd11); end
        redirect_i = 1'b1; redirect_pc_i = 32'd18;
        #1;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== rom_word(32'd10)) begin n_fail++; $display("FAIL redir_cycle: got %b/%h want 1/%h", valid_o, instr_o, rom_word(32'd10)); end
        tick();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'd18 || instr_pc_o !== 32'd11) begin n_fail++; $display("FAIL redir_pc: got %h/%h want 18/11", pc_o, instr_pc_o); end
        n_checks++; if (instr_o !== NOP || valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_squash: got %h/%b want %h/0", instr_o, valid_o, NOP); end
        tick();
        n_checks++; if (valid_o !== 1'b1 || instr_o !== rom_word(32'd18)) begin n_fail++; $display("FAIL redir_target: got %b/%h want 1/%h", valid_o, instr_o, rom_word(32'd18)); end
        n_checks++; if (instr_pc_o !== 32'd18 || pc_o !== 32'd19) begin n_fail++; $display("FAIL redir_target_pc: got %h/%h want 18/19", instr_pc_o, pc_o); end
    endtask

    task automatic test_redirect_stall();
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'd40;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b want 0", valid_o); end
        tick();
        stall_i = 1'b0; redirect_pc_i = 32'd19;
        #1;
        n_checks++; if (pc_o !== 32'd40) begin n_fail++; $display("FAIL rs_pc: got %h want %h", pc_o, 32'd40); end
        n_checks++; if (instr_o !== NOP || valid_o !== 1'b0) begin n_fail++; $display("FAIL rs_squash: got %h/%b want %h/0", instr_o, valid_o, NOP); end
        tick();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'd19 || instr_pc_o !== 32'd40) begin n_fail++; $display("FAIL resquash_pc: got %h/%h want 19/40", pc_o, instr_pc_o); end
        n_checks++; if (instr_o !== NOP || valid_o !== 1'b0) begin n_fail++; $display("FAIL resquash_out: got %h/%b want %h/0", instr_o, valid_o, NOP); end
    endtask

    task automatic test_halt();
        tick();
        n_checks++; if (instr_o !== NOP || valid_o !== 1'b0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL end_seen: got %h/%b/%b want %h/0/0", instr_o, valid_o, halted_o, NOP); end
        n_checks++; if (pc_o !== 32'd20) begin n_fail++; $display("FAIL end_seen_pc: got %h want %h", pc_o, 32'd20); end
        redirect_i = 1'b1; redirect_pc_i = 32'd5;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want 1", k, halted_o); end
            n_checks++; if (pc_o !== 32'd20 || instr_pc_o !== 32'd19) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h/%h want 20/19", k, pc_o, instr_pc_o); end
            n_checks++; if (instr_o !== NOP || valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_out[%0d]: got %h/%b want %h/0", k, instr_o, valid_o, NOP); end
        end
        n_checks++; if (cnt_fetch_o !== (PERF ? 32'd11 : 32'd0)) begin n_fail++; $display("FAIL halt_fetch_cnt: got %0d want %0d", cnt_fetch_o, PERF ? 11 : 0); end
        n_checks++; if (cnt_stall_o !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL halt_stall_cnt: got %0d want %0d", cnt_stall_o, PERF ? 4 : 0); end
        redirect_i = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'd0 || instr_pc_o !== 32'd0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got %h/%h/%b want 0/0/0", pc_o, instr_pc_o, halted_o); end
        n_checks++; if (cnt_fetch_o !== 32'd0 || cnt_stall_o !== 32'd0) begin n_fail++; $display("FAIL halt_reset_cnt: got %0d/%0d want 0/0", cnt_fetch_o, cnt_stall_o); end
    endtask

    task automatic test_wrap();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (pc_o !== 32'd1 || valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_boot: got %h/%b want 1/1", pc_o, valid_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_top: got %h want %h", pc_o, 32'hFFFF_FFFF); end
        tick();
        n_checks++; if (pc_o !== 32'd0 || instr_pc_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pc: got %h/%h want 0/ffffffff", pc_o, instr_pc_o); end
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h1000_FFFF) begin n_fail++; $display("FAIL wrap_instr: got %b/%h want 1/%h", valid_o, instr_o, 32'h1000_FFFF); end
    endtask

    task automatic test_saturation();
        sat_rst_n = 1'b1;
        sat_fetch = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        sat_fetch = 1'b0;
        n_checks++; if (sat_cnt_fetch !== 3'd7) begin n_fail++; $display("FAIL sat_fetch: got %0d want 7", sat_cnt_fetch); end
        sat_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (sat_cnt_stall !== 3'd3) begin n_fail++; $display("FAIL sat_stall_mid: got %0d want 3", sat_cnt_stall); end
        sat_freeze = 1'b1;
        tick(); tick();
        n_checks++; if (sat_cnt_stall !== 3'd3) begin n_fail++; $display("FAIL sat_freeze: got %0d want 3", sat_cnt_stall); end
        sat_freeze = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        sat_stall = 1'b0;
        n_checks++; if (sat_cnt_stall !== 3'd7 || sat_cnt_fetch !== 3'd7) begin n_fail++; $display("FAIL sat_pinned: got %0d/%0d want 7/7", sat_cnt_stall, sat_cnt_fetch); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
